// File: rtl/instr_pkg.sv
// Shared constants for the instruction encoder: field widths, op classes,
// MIPS primary opcodes, FSM state encoding and the request payload.
package instr_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned CNT_W   = 9;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned TGT_W   = 26;
  localparam int unsigned OPC_W   = 6;

  typedef enum logic [OP_W-1:0] {
    OP_R    = 3'd0,
    OP_LW   = 3'd1,
    OP_SW   = 3'd2,
    OP_BEQ  = 3'd3,
    OP_ADDI = 3'd4,
    OP_J    = 3'd5,
    OP_JAL  = 3'd6,
    OP_ILL  = 3'd7
  } op_e;

  localparam logic [OPC_W-1:0] OPC_R    = 6'b000000;
  localparam logic [OPC_W-1:0] OPC_LW   = 6'b100011;
  localparam logic [OPC_W-1:0] OPC_SW   = 6'b101011;
  localparam logic [OPC_W-1:0] OPC_BEQ  = 6'b000100;
  localparam logic [OPC_W-1:0] OPC_ADDI = 6'b001000;
  localparam logic [OPC_W-1:0] OPC_J    = 6'b000010;
  localparam logic [OPC_W-1:0] OPC_JAL  = 6'b000011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FULL = 2'd2
  } state_e;

  typedef struct packed {
    op_e                op;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   rd;
    logic [FUNCT_W-1:0] funct;
    logic [IMM_W-1:0]   imm;
    logic [TGT_W-1:0]   target;
  } instr_req_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational packing of an instruction request into a 32-bit MIPS word;
// flags the illegal op class instead of producing a word.
module instr_pack
  import instr_pkg::*;
(
  input  instr_req_t          req,
  output logic [WORD_W-1:0]   word,
  output logic                illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (req.op)
      OP_R:    word = {OPC_R, req.rs, req.rt, req.rd, 5'b00000, req.funct};
      OP_LW:   word = {OPC_LW, req.rs, req.rt, req.imm};
      OP_SW:   word = {OPC_SW, req.rs, req.rt, req.imm};
      OP_BEQ:  word = {OPC_BEQ, req.rs, req.rt, req.imm};
      OP_ADDI: word = {OPC_ADDI, req.rs, req.rt, req.imm};
      OP_J:    word = {OPC_J, req.target};
      OP_JAL:  word = {OPC_JAL, req.target};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts instruction requests, encodes them and streams
// one registered instruction-memory write per accepted legal request.
module instr_encoder
  import instr_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_W-1:0]     in_op,
  input  logic [REG_W-1:0]    in_rs,
  input  logic [REG_W-1:0]    in_rt,
  input  logic [REG_W-1:0]    in_rd,
  input  logic [FUNCT_W-1:0]  in_funct,
  input  logic [IMM_W-1:0]    in_imm,
  input  logic [TGT_W-1:0]    in_target,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [WORD_W-1:0]   imem_wdata,
  output logic [CNT_W-1:0]    count,
  output logic                full,
  output logic                err
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q;
  logic [WORD_W-1:0]   word;
  logic                illegal;
  logic                accept;
  logic                write;
  instr_req_t          req;

  assign req = '{op: op_e'(in_op), rs: in_rs, rt: in_rt, rd: in_rd,
                 funct: in_funct, imm: in_imm, target: in_target};

  instr_pack u_pack (
    .req     (req),
    .word    (word),
    .illegal (illegal)
  );

  assign accept = in_valid && in_ready;
  assign write  = accept && !illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Start wins over stop; the write landing on the top address exhausts the space.
  always_comb begin
    state_d = state_q;
    if (start)                                state_d = S_RUN;
    else if (stop)                            state_d = S_IDLE;
    else if (write && (ptr_q == '1))          state_d = S_FULL;
  end

  always_comb begin
    in_ready = 1'b0;
    full     = 1'b0;
    if (state_q == S_RUN && !start && !stop) in_ready = 1'b1;
    if (state_q == S_FULL)                   full     = 1'b1;
  end

  // Pointer saturates at the top address; FULL blocks further accepts anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      count      <= '0;
      err        <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= write;
      if (write) begin
        imem_addr  <= ptr_q;
        imem_wdata <= word;
      end
      if (start) begin
        ptr_q <= start_addr;
        count <= '0;
        err   <= 1'b0;
      end else begin
        if (write) begin
          count <= count + CNT_W'(1);
          if (ptr_q != '1) ptr_q <= ptr_q + ADDR_W'(1);
        end
        if (accept && illegal) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed literal scenarios plus
// randomized traffic compared every cycle against a behavioural model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0;
  logic [7:0]  start_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
  logic [5:0]  in_funct = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  count;
  logic        full, err;

  int n_cmp = 0;
  int n_bad = 0;

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .start_addr(start_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct), .in_imm(in_imm),
    .in_target(in_target), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .count(count), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [2:0] op, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn,
      input logic [15:0] imm, input logic [25:0] tgt);
    case (op)
      3'd0: return {6'd0, rs, rt, rd, 5'd0, fn};
      3'd1: return {6'd35, rs, rt, imm};
      3'd2: return {6'd43, rs, rt, imm};
      3'd3: return {6'd4, rs, rt, imm};
      3'd4: return {6'd8, rs, rt, imm};
      3'd5: return {6'd2, tgt};
      3'd6: return {6'd3, tgt};
      default: return 32'd0;
    endcase
  endfunction

  // Model: a loaded program has a next free address 0..256; 256 means exhausted.
  bit          m_active = 1'b0;
  int          m_next = 0;
  int          m_count = 0;
  bit          m_err = 1'b0;
  bit          m_we = 1'b0;
  int          m_addr = 0;
  logic [31:0] m_data = '0;
  logic        m_rdy;
  logic        m_acc;

  assign m_rdy = m_active && (m_next < 256) && !start && !stop;
  assign m_acc = m_rdy && in_valid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0; m_next <= 0; m_count <= 0; m_err <= 1'b0;
      m_we <= 1'b0; m_addr <= 0; m_data <= '0;
    end else begin
      m_we <= m_acc && (in_op != 3'd7);
      if (m_acc && in_op != 3'd7) begin
        m_addr <= m_next;
        m_data <= enc(in_op, in_rs, in_rt, in_rd, in_funct, in_imm, in_target);
      end
      if (start) begin
        m_active <= 1'b1; m_next <= int'(start_addr); m_count <= 0; m_err <= 1'b0;
      end else if (stop) begin
        m_active <= 1'b0;
      end else if (m_acc) begin
        if (in_op == 3'd7) m_err <= 1'b1;
        else begin
          m_next  <= m_next + 1;
          m_count <= m_count + 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("in_ready", 32'(in_ready), 32'(m_rdy));
    chk("imem_we", 32'(imem_we), 32'(m_we));
    chk("imem_addr", 32'(imem_addr), 32'(m_addr));
    chk("imem_wdata", imem_wdata, m_data);
    chk("count", 32'(count), 32'(m_count));
    chk("full", 32'(full), 32'(m_active && m_next == 256));
    chk("err", 32'(err), 32'(m_err));
  endtask

  // One cycle: compare at the falling edge, then land just after the rising edge.
  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [5:0] fn, input logic [15:0] imm,
      input logic [25:0] tgt);
    in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
    in_funct = fn; in_imm = imm; in_target = tgt;
  endtask

  task automatic do_start(input logic [7:0] a);
    in_valid = 1'b0; start = 1'b1; start_addr = a;
    step();
    start = 1'b0;
  endtask

  initial begin
    chk("model_enc_addi", enc(3'd4, 5'd0, 5'd8, 5'd0, 6'd0, 16'd5, 26'd0), 32'h20080005);
    chk("model_enc_j", enc(3'd5, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10), 32'h08000010);

    step(); step();
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;

    do_start(8'h10);
    req(3'd4, 5'd0, 5'd8, 5'd0, 6'd0, 16'd5, 26'd0);
    step();
    chk("addi_we", 32'(imem_we), 32'd1);
    chk("addi_addr", 32'(imem_addr), 32'h10);
    chk("addi_data", imem_wdata, 32'h20080005);
    chk("addi_count", 32'(count), 32'd1);

    do_start(8'h10);
    req(3'd1, 5'd29, 5'd8, 5'd0, 6'd0, 16'd4, 26'd0);
    step();
    chk("lw_data", imem_wdata, 32'h8FA80004);
    chk("lw_addr", 32'(imem_addr), 32'h10);
    req(3'd0, 5'd9, 5'd10, 5'd8, 6'h20, 16'd0, 26'd0);
    step();
    chk("r_we", 32'(imem_we), 32'd1);
    chk("r_data", imem_wdata, 32'h012A4020);
    chk("r_addr", 32'(imem_addr), 32'h11);
    req(3'd5, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10);
    step();
    chk("j_data", imem_wdata, 32'h08000010);
    req(3'd6, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10);
    step();
    chk("jal_data", imem_wdata, 32'h0C000010);
    chk("jal_addr", 32'(imem_addr), 32'h13);
    req(3'd7, 5'd1, 5'd2, 5'd3, 6'd4, 16'd5, 26'd6);
    step();
    chk("ill_we", 32'(imem_we), 32'd0);
    chk("ill_err", 32'(err), 32'd1);
    req(3'd4, 5'd1, 5'd2, 5'd0, 6'd0, 16'hFFFF, 26'd0);
    step();
    chk("after_ill_addr", 32'(imem_addr), 32'h14);
    chk("after_ill_err", 32'(err), 32'd1);
    do_start(8'h20);
    chk("err_cleared", 32'(err), 32'd0);

    do_start(8'hFE);
    req(3'd4, 5'd0, 5'd1, 5'd0, 6'd0, 16'd1, 26'd0);
    step();
    chk("fe_addr", 32'(imem_addr), 32'hFE);
    step();
    chk("ff_addr", 32'(imem_addr), 32'hFF);
    chk("ff_full", 32'(full), 32'd1);
    chk("ff_ready", 32'(in_ready), 32'd0);
    step();
    chk("third_we", 32'(imem_we), 32'd0);
    chk("third_count", 32'(count), 32'd2);
    in_valid = 1'b0; stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_full", 32'(full), 32'd0);
    chk("stop_ready", 32'(in_ready), 32'd0);

    do_start(8'h00);
    req(3'd0, 5'd3, 5'd4, 5'd5, 6'h21, 16'd0, 26'd0);
    for (int i = 0; i < 256; i++) step();
    chk("full256_count", 32'(count), 32'd256);
    chk("full256_full", 32'(full), 32'd1);
    in_valid = 1'b0;

    do_start(8'h40);
    req(3'd4, 5'd0, 5'd8, 5'd0, 6'd0, 16'd5, 26'd0);
    #2 rst_n = 1'b0;
    step();
    chk("rstacc_we", 32'(imem_we), 32'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    step();
    chk("rstacc_we2", 32'(imem_we), 32'd0);
    chk("rstacc_wdata", imem_wdata, 32'd0);
    chk("rstacc_count", 32'(count), 32'd0);

    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(0, 39) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      start_addr = $urandom_range(0, 1) ? 8'($urandom_range(240, 255)) : 8'($urandom);
      req(3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
          16'($urandom), 26'($urandom));
      in_valid = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      step();
      rst_n = 1'b1;
    end
    start = 1'b0; stop = 1'b0; in_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, pulse to begin a program load at start_addr.
REQ-004 SHALL have port stop, input, 1, pulse to end the load and return to idle.
REQ-005 SHALL have port start_addr, input, 8, first instruction-memory word address.
REQ-006 SHALL have port in_valid, input, 1, instruction request valid.
REQ-007 SHALL have port in_ready, output, 1, encoder accepts a request this cycle.
REQ-008 SHALL have port in_op, input, 3, op class: 0 R-type, 1 lw, 2 sw, 3 beq, 4 addi, 5 j, 6 jal, 7 illegal.
REQ-009 SHALL have ports in_rs, in_rt and in_rd, each input, 5, register fields.
REQ-010 SHALL have port in_funct, input, 6, R-type funct field.
REQ-011 SHALL have port in_imm, input, 16, I-type immediate.
REQ-012 SHALL have port in_target, input, 26, J-type target.
REQ-013 SHALL have port imem_we, output, 1, instruction-memory write strobe.
REQ-014 SHALL have port imem_addr, output, 8, word address of the write.
REQ-015 SHALL have port imem_wdata, output, 32, encoded instruction word.
REQ-016 SHALL have port count, output, 9, number of words written since the last start.
REQ-017 SHALL have port full, output, 1, address space exhausted.
REQ-018 SHALL have port err, output, 1, sticky flag for a rejected illegal op.

Function
REQ-019 SHALL implement the FSM states IDLE, RUN and FULL.
REQ-020 SHALL take these transitions: IDLE->RUN on start; RUN->FULL when the write to address 8'hFF issues; RUN or FULL->IDLE on stop; start in RUN or FULL restarts (->RUN).
REQ-021 SHALL load the address pointer from start_addr, clear count and clear err on start.
REQ-022 SHALL drive in_ready=1 only in RUN and only when start and stop are both low.
REQ-023 SHALL accept a request when in_valid && in_ready; in_valid may be held, and one request is consumed per accepting cycle.
REQ-024 SHALL encode fields as follows:
- R-type: {6'b000000, rs, rt, rd, 5'b0, funct}
- lw: {6'b100011, rs, rt, imm}
- sw: {6'b101011, rs, rt, imm}
- beq: {6'b000100, rs, rt, imm}
- addi: {6'b001000, rs, rt, imm}
- j: {6'b000010, target}
- jal: {6'b000011, target}
REQ-025 SHALL register the write: an accept in cycle N gives imem_we=1 for exactly one cycle in N+1, with imem_addr = pointer at accept and imem_wdata = encoded word.
REQ-026 SHALL sustain a throughput of one word per cycle.
REQ-027 SHALL increment the pointer and count by 1 per issued write, with no wrap.
REQ-028 SHALL handle in_op=7 as follows: accepted (handshake completes), no write, pointer unchanged, err=1 from N+1 until the next start or reset.
REQ-029 SHALL let a write already registered complete in its cycle even if start or stop is asserted in that cycle.
REQ-030 SHALL give full the state FULL; in_ready=0 in FULL.
REQ-031 SHALL enter FULL after the write at 8'hFF, so start_addr=8'h00 allows 256 writes and count=256.
REQ-032 SHALL give start priority over stop when both are asserted together.

Reset
REQ-033 SHALL asynchronously force, while rst_n=0: state IDLE, pointer 0, count 0, err 0, full 0, imem_we 0, imem_addr 0, imem_wdata 0, in_ready 0.
REQ-034 SHALL drop any pending write when reset is asserted mid-load; no imem_we pulse follows deassertion.
REQ-035 SHALL release from reset synchronously in effect: the first start is honoured on the first rising edge with rst_n=1.

Structure
REQ-036 SHALL place opcode constants (R-type, lw, sw, beq, addi, j, jal), op-class codes and FSM state encodings in shared package instr_pkg, also used by main decoding logic.
REQ-037 SHALL place the combinational field packing in sub-module instr_pack (op class plus fields in; 32-bit word and illegal flag out); instr_encoder holds the FSM, pointer, counters and output register.

Verification
REQ-038 SHALL cover: start_addr=8'h10, addi rs=0 rt=8 imm=5 -> next cycle imem_we=1, addr 8'h10, wdata 32'h20080005, count=1.
REQ-039 SHALL cover: back-to-back lw rs=29 rt=8 imm=4, then R-type rs=9 rt=10 rd=8 funct=6'h20 -> writes 32'h8FA80004 @8'h10 and 32'h012A4020 @8'h11 on consecutive cycles.
REQ-040 SHALL cover: j target=26'h10, then jal target=26'h10 -> 32'h08000010, 32'h0C000010.
REQ-041 SHALL cover: in_op=7 between two valid ops -> no write for it, addresses stay contiguous, err=1 until the next start.
REQ-042 SHALL cover: start_addr=8'hFE, three requests held valid -> two writes (8'hFE, 8'hFF), full=1, in_ready=0, third request not accepted; stop -> IDLE.
REQ-043 SHALL cover: rst_n low during the accept cycle -> no imem_we afterwards, all outputs at reset values.
